booth_arbiter: RTL

Round-robin scheduler sharing one 8-bit signed Booth multiplier among `N_REQ` requesters. It latches a winner's operands and sequences the multiplier's start/load/run protocol. It captures the 16-bit product from the multiplier's byte-serial output bus and returns it to the winner with a one-cycle done pulse. It sits between the client blocks and the multiplier's `bgn`/`ibus`/`obus`/`stop` pins.

---
 rtl/booth_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/booth_arbiter.sv
// booth_arbiter: round-robin front end sharing one byte-serial signed Booth multiplier.
// Optional feature: define BOOTH_ARB_TIMEOUT_EN for a RUN watchdog that completes with err.
module booth_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   mcand,
  input  logic [8*N_REQ-1:0]   mplier,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic signed [15:0]   result,
  output logic                 err,
  output logic                 busy,
  output logic                 bgn,
  output logic [7:0]           ibus,
  input  logic [7:0]           obus,
  input  logic                 stop
);
  localparam int DATA_W = 8;
  localparam int IDX_W  = $clog2(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_M = 3'd1,
    S_LOAD_Q = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]         last, idx, win_idx;
  logic                     win_vld;
  logic                     timeout_hit;
  logic [DATA_W-1:0]        mcand_arr  [N_REQ];
  logic [DATA_W-1:0]        mplier_arr [N_REQ];
  logic signed [DATA_W-1:0] mplier_lat;
  logic [DATA_W-1:0]        hist_old, hist_new;

  logic [N_REQ-1:0]         gnt_nxt, done_nxt;
  logic signed [15:0]       result_nxt;
  logic                     err_nxt, busy_nxt, bgn_nxt;
  logic [DATA_W-1:0]        ibus_nxt;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      mcand_arr[i]  = mcand[8*i +: 8];
      mplier_arr[i] = mplier[8*i +: 8];
    end
  end

  // Scan from farthest to nearest so the requester closest after `last` wins.
  always_comb begin
    logic [IDX_W-1:0] c;
    win_vld = 1'b0;
    win_idx = '0;
    c       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      c = IDX_W'((int'(last) + k) % N_REQ);
      if (req[c]) begin
        win_vld = 1'b1;
        win_idx = c;
      end
    end
  end

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] run_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      run_cnt <= '0;
    else if (state != S_RUN)
      run_cnt <= '0;
    else
      run_cnt <= run_cnt + CNT_W'(1);
  end

  assign timeout_hit = (state == S_RUN) && (run_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= S_IDLE;
      idx   <= '0;
      last  <= IDX_W'(N_REQ - 1);
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && win_vld)
        idx <= win_idx;
      if (state == S_DONE)
        last <= idx;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (win_vld) state_nxt = S_LOAD_M;
      S_LOAD_M: state_nxt = S_LOAD_Q;
      S_LOAD_Q: state_nxt = S_RUN;
      S_RUN:    if (stop || timeout_hit) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered, so their next values are derived from the next state.
  always_comb begin
    gnt_nxt    = '0;
    done_nxt   = '0;
    bgn_nxt    = 1'b0;
    ibus_nxt   = '0;
    err_nxt    = 1'b0;
    busy_nxt   = (state_nxt != S_IDLE);
    result_nxt = result;
    case (state_nxt)
      S_LOAD_M: begin
        bgn_nxt  = 1'b1;
        ibus_nxt = mcand_arr[win_idx];
        gnt_nxt  = onehot(win_idx);
      end
      S_LOAD_Q: begin
        ibus_nxt = mplier_lat;
        gnt_nxt  = onehot(idx);
      end
      S_RUN: gnt_nxt = onehot(idx);
      S_DONE: begin
        done_nxt   = onehot(idx);
        err_nxt    = timeout_hit && !stop;
        result_nxt = stop ? signed'({hist_old, hist_new}) : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      gnt    <= '0;
      done   <= '0;
      result <= '0;
      err    <= 1'b0;
      busy   <= 1'b0;
      bgn    <= 1'b0;
      ibus   <= '0;
    end else begin
      gnt    <= gnt_nxt;
      done   <= done_nxt;
      result <= result_nxt;
      err    <= err_nxt;
      busy   <= busy_nxt;
      bgn    <= bgn_nxt;
      ibus   <= ibus_nxt;
    end
  end

  // Operand latch and product-byte history: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && win_vld)
      mplier_lat <= mplier_arr[win_idx];
    if (state == S_RUN) begin
      hist_old <= hist_new;
      hist_new <= obus;
    end
  end

endmodule
